boom_counter_game: RTL and testbench

- Parametrised, clocked successor to the combinational "boom" detector used in the counting-game labs.
- Holds its own count value, which advances on `step` or loads on `load`.
- Flags a "boom" when the current value is a multiple of DIVISOR or, in mode 1, when its last decimal digit equals DIVISOR%10.
- Tracks divisibility with residue registers and an iterative load-time reduction FSM instead of a `%` operator.
- Drives the 7-seg decoder path (`outdecod`) and a pulse-stretched LED (`outled`).

---
 rtl/boom_pkg.sv | 21 ++
 rtl/boom_residue_calc.sv | 65 ++++++
 rtl/boom_counter_game.sv | 161 ++++++++++++++++
 tb/tb_boom_counter_game.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boom_pkg.sv
// Shared types and constants for the boom counting-game block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, decimal base constant and the helper used to
// derive the "last digit" boom value from the divisor at elaboration time.
package boom_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    localparam int DEC_BASE = 10;

    // Elaboration-time only: the digit a value must end in to boom in mode 1.
    function automatic int dec_digit(input int divisor);
        return divisor % DEC_BASE;
    endfunction

endpackage

// File: rtl/boom_residue_calc.sv
// Iterative residue unit: reduces a loaded value modulo DIVISOR and modulo 10.
// Latency: max(v/DIVISOR, v/10) cycles after start until done asserts.
// Backpressure: none; start always wins and restarts the reduction.
//
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   start           - capture value into both working registers
//   value           - value to reduce
//   done            - both working registers are below their moduli
//   res_d, res_10   - reduced residues, valid while done is high
module boom_residue_calc
    import boom_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int DIVISOR = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             done,
    output logic [WIDTH-1:0] res_d,
    output logic [WIDTH-1:0] res_10
);

    localparam logic [WIDTH-1:0] DIV_W = WIDTH'(DIVISOR);
    localparam logic [WIDTH-1:0] DEC_W = WIDTH'(DEC_BASE);

    logic [WIDTH-1:0] tmp_d_q, tmp_d_d;
    logic [WIDTH-1:0] tmp_10_q, tmp_10_d;

    // One conditional subtraction per modulus per cycle; once both are below
    // their moduli the registers hold, so the unit is quiet while idle.
    always_comb begin
        tmp_d_d  = tmp_d_q;
        tmp_10_d = tmp_10_q;
        if (start) begin
            tmp_d_d  = value;
            tmp_10_d = value;
        end else begin
            if (tmp_d_q >= DIV_W) begin
                tmp_d_d = tmp_d_q - DIV_W;
            end
            if (tmp_10_q >= DEC_W) begin
                tmp_10_d = tmp_10_q - DEC_W;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmp_d_q  <= '0;
            tmp_10_q <= '0;
        end else begin
            tmp_d_q  <= tmp_d_d;
            tmp_10_q <= tmp_10_d;
        end
    end

    // A start in the same cycle invalidates the current working values.
    assign done   = !start && (tmp_d_q < DIV_W) && (tmp_10_q < DEC_W);
    assign res_d  = tmp_d_q;
    assign res_10 = tmp_10_q;

endmodule

// File: rtl/boom_counter_game.sv
// Counting-game value register with divisor / last-digit boom detection.
// Latency: step -> count 1 cycle; stepped boom -> outled/boom_total 2 cycles.
// Backpressure: step is dropped while busy; load always accepted (restarts CALC).
//
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   step        - advance count by one (ignored while busy)
//   load        - load load_val and recompute residues
//   load_val    - value to load
//   mode        - 0: multiples only, 1: multiples or matching last digit
//   count       - current value
//   outdecod    - all-ones on boom, else count
//   outled      - boom indicator stretched over BOOM_HOLD cycles
//   busy        - residue recomputation in progress
//   wrap        - one-cycle pulse after count wraps to zero
//   boom_total  - saturating count of stepped booms
module boom_counter_game
    import boom_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int DIVISOR   = 6,
    parameter int BOOM_HOLD = 3,
    parameter int TOT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] outdecod,
    output logic             outled,
    output logic             busy,
    output logic             wrap,
    output logic [TOT_W-1:0] boom_total
);

    localparam int               HOLD_W     = $clog2(BOOM_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LD   = HOLD_W'(BOOM_HOLD);
    localparam logic [WIDTH-1:0] DIV_W      = WIDTH'(DIVISOR);
    localparam logic [WIDTH-1:0] DEC_W      = WIDTH'(DEC_BASE);
    localparam logic [WIDTH-1:0] BOOM_DIGIT = WIDTH'(dec_digit(DIVISOR));

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  res_d_q, res_d_d;
    logic [WIDTH-1:0]  res_10_q, res_10_d;
    logic              stepped_q, stepped_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              wrap_q, wrap_d;
    logic [TOT_W-1:0]  total_q, total_d;

    logic              calc_done;
    logic [WIDTH-1:0]  calc_res_d;
    logic [WIDTH-1:0]  calc_res_10;
    logic              is_boom;

    // A load restarts the reduction regardless of the current state.
    boom_residue_calc #(
        .WIDTH   (WIDTH),
        .DIVISOR (DIVISOR)
    ) u_residue (
        .clk    (clk),
        .rst    (rst),
        .start  (load),
        .value  (load_val),
        .done   (calc_done),
        .res_d  (calc_res_d),
        .res_10 (calc_res_10)
    );

    // Residues are only trustworthy outside CALC, so busy masks the boom.
    assign is_boom = (state_q == IDLE) && (count_q != '0) &&
                     ((res_d_q == '0) || (mode && (res_10_q == BOOM_DIGIT)));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        res_d_d   = res_d_q;
        res_10_d  = res_10_q;
        stepped_d = 1'b0;
        wrap_d    = 1'b0;
        hold_d    = hold_q;
        total_d   = total_q;

        // Boom from the previous step is judged on the now-updated count.
        // A new boom reloads the hold so back-to-back booms merge.
        if (stepped_q && is_boom) begin
            hold_d = HOLD_LD;
            if (total_q != '1) begin
                total_d = total_q + TOT_W'(1);
            end
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    count_d = load_val;
                    state_d = CALC;
                end else if (step) begin
                    stepped_d = 1'b1;
                    if (count_q == '1) begin
                        count_d  = '0;
                        res_d_d  = '0;
                        res_10_d = '0;
                        wrap_d   = 1'b1;
                    end else begin
                        count_d  = count_q + WIDTH'(1);
                        res_d_d  = (res_d_q == DIV_W - WIDTH'(1)) ? '0 : res_d_q + WIDTH'(1);
                        res_10_d = (res_10_q == DEC_W - WIDTH'(1)) ? '0 : res_10_q + WIDTH'(1);
                    end
                end
            end
            CALC: begin
                if (load) begin
                    count_d = load_val;
                end else if (calc_done) begin
                    res_d_d  = calc_res_d;
                    res_10_d = calc_res_10;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            res_d_q   <= '0;
            res_10_q  <= '0;
            stepped_q <= 1'b0;
            hold_q    <= '0;
            wrap_q    <= 1'b0;
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            res_d_q   <= res_d_d;
            res_10_q  <= res_10_d;
            stepped_q <= stepped_d;
            hold_q    <= hold_d;
            wrap_q    <= wrap_d;
            total_q   <= total_d;
        end
    end

    assign count      = count_q;
    assign outdecod   = is_boom ? {WIDTH{1'b1}} : count_q;
    assign outled     = (hold_q != '0);
    assign busy       = (state_q == CALC);
    assign wrap       = wrap_q;
    assign boom_total = total_q;

endmodule

// File: tb/tb_boom_counter_game.sv
module tb_boom_counter_game;

    localparam int W    = 5;
    localparam int D    = 6;
    localparam int HOLD = 3;
    localparam int TW   = 8;

    logic          clk;
    logic          rst;
    logic          step;
    logic          load;
    logic [W-1:0]  load_val;
    logic          mode;
    logic [W-1:0]  count;
    logic [W-1:0]  outdecod;
    logic          outled;
    logic          busy;
    logic          wrap;
    logic [TW-1:0] boom_total;

    boom_counter_game #(
        .WIDTH     (W),
        .DIVISOR   (D),
        .BOOM_HOLD (HOLD),
        .TOT_W     (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .load       (load),
        .load_val   (load_val),
        .mode       (mode),
        .count      (count),
        .outdecod   (outdecod),
        .outled     (outled),
        .busy       (busy),
        .wrap       (wrap),
        .boom_total (boom_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  count;
        logic [W-1:0]  outdecod;
        logic          outled;
        logic          busy;
        logic          wrap;
        logic [TW-1:0] total;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state (behavioural, uses % and a busy-length formula)
    logic [W-1:0] m_count;
    int           m_busy;
    logic         m_pend;
    int           m_hold;
    int           m_total;
    logic         m_wrap;
    logic         cur_mode;

    function automatic logic m_boom(input logic [W-1:0] c, input logic b, input logic md);
        int v;
        v = int'(c);
        return !b && (v != 0) && (((v % D) == 0) || (md && ((v % 10) == (D % 10))));
    endfunction

    function automatic int busy_len(input logic [W-1:0] v);
        int a;
        int b;
        a = int'(v) / D;
        b = int'(v) / 10;
        return ((a > b) ? a : b) + 1;
    endfunction

    // Drives one cycle of inputs, advances the model and queues the
    // outputs expected just after the coming rising edge.
    task automatic drive(input logic r, input logic s, input logic l, input logic [W-1:0] lv);
        exp_t e;
        @(negedge clk);
        rst      = r;
        step     = s;
        load     = l;
        load_val = lv;
        mode     = cur_mode;
        if (r) begin
            m_count = '0; m_busy = 0; m_pend = 1'b0; m_hold = 0; m_total = 0; m_wrap = 1'b0;
        end else begin
            if (m_pend && m_boom(m_count, m_busy > 0, cur_mode)) begin
                m_hold = HOLD;
                if (m_total < (2**TW - 1)) m_total = m_total + 1;
            end else if (m_hold > 0) begin
                m_hold = m_hold - 1;
            end
            m_pend = 1'b0;
            m_wrap = 1'b0;
            if (l) begin
                m_count = lv;
                m_busy  = busy_len(lv);
            end else if (m_busy > 0) begin
                m_busy = m_busy - 1;
            end else if (s) begin
                if (m_count == 5'd31) begin
                    m_count = '0;
                    m_wrap  = 1'b1;
                end else begin
                    m_count = m_count + 5'd1;
                end
                m_pend = 1'b1;
            end
        end
        e.count    = m_count;
        e.outdecod = m_boom(m_count, m_busy > 0, cur_mode) ? 5'h1f : m_count;
        e.outled   = (m_hold != 0);
        e.busy     = (m_busy > 0);
        e.wrap     = m_wrap;
        e.total    = TW'(m_total);
        exp_q.push_back(e);
    endtask

    // Scoreboard: pops one expectation per edge that had stimulus queued.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (count !== e.count) begin
                errors++; $display("FAIL sb_count t=%0t got=%0d exp=%0d", $time, count, e.count);
            end
            checks++;
            if (outdecod !== e.outdecod) begin
                errors++; $display("FAIL sb_outdecod t=%0t got=%0d exp=%0d", $time, outdecod, e.outdecod);
            end
            checks++;
            if (outled !== e.outled) begin
                errors++; $display("FAIL sb_outled t=%0t got=%0b exp=%0b", $time, outled, e.outled);
            end
            checks++;
            if (busy !== e.busy) begin
                errors++; $display("FAIL sb_busy t=%0t got=%0b exp=%0b", $time, busy, e.busy);
            end
            checks++;
            if (wrap !== e.wrap) begin
                errors++; $display("FAIL sb_wrap t=%0t got=%0b exp=%0b", $time, wrap, e.wrap);
            end
            checks++;
            if (boom_total !== e.total) begin
                errors++; $display("FAIL sb_total t=%0t got=%0d exp=%0d", $time, boom_total, e.total);
            end
        end
    end

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0);
            settle();
            if (!busy) return;
        end
        checks++; errors++;
        $display("FAIL wait_idle busy stuck got=%0b exp=0", busy);
    endtask

    task automatic test_reset();
        cur_mode = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0);
        settle();
        checks++;
        if (count !== 5'd0 || outdecod !== 5'd0 || outled !== 1'b0 || busy !== 1'b0 ||
            wrap !== 1'b0 || boom_total !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got count=%0d dec=%0d led=%0b busy=%0b wrap=%0b tot=%0d exp all 0",
                     count, outdecod, outled, busy, wrap, boom_total);
        end
    endtask

    task automatic test_step_boom();
        int highs;
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, '0);
        settle();
        checks++;
        if (count !== 5'd6) begin errors++; $display("FAIL step6_count got=%0d exp=6", count); end
        checks++;
        if (outdecod !== 5'h1f) begin errors++; $display("FAIL step6_outdecod got=%0d exp=31", outdecod); end
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0);
            settle();
            if (outled === 1'b1) highs++;
        end
        checks++;
        if (highs != HOLD) begin errors++; $display("FAIL led_stretch got=%0d exp=%0d", highs, HOLD); end
        checks++;
        if (boom_total !== 8'd1) begin errors++; $display("FAIL step_total got=%0d exp=1", boom_total); end
        drive(1'b0, 1'b1, 1'b0, '0);
        settle();
        checks++;
        if (outdecod !== 5'd7) begin errors++; $display("FAIL step7_outdecod got=%0d exp=7", outdecod); end
    endtask

    task automatic test_wrap();
        logic [TW-1:0] tot0;
        tot0 = boom_total;
        drive(1'b0, 1'b0, 1'b1, 5'd31);
        wait_idle();
        drive(1'b0, 1'b1, 1'b0, '0);
        settle();
        checks++;
        if (count !== 5'd0 || wrap !== 1'b1 || outdecod !== 5'd0) begin
            errors++;
            $display("FAIL wrap_pulse got count=%0d wrap=%0b dec=%0d exp 0/1/0", count, wrap, outdecod);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        settle();
        checks++;
        if (wrap !== 1'b0 || outled !== 1'b0) begin
            errors++; $display("FAIL wrap_end got wrap=%0b led=%0b exp 0/0", wrap, outled);
        end
        checks++;
        if (boom_total !== tot0) begin errors++; $display("FAIL wrap_total got=%0d exp=%0d", boom_total, tot0); end
    endtask

    task automatic test_load_boom();
        int n;
        logic [TW-1:0] tot0;
        tot0 = boom_total;
        drive(1'b0, 1'b0, 1'b1, 5'd18);
        settle();
        n = 0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            n++;
            checks++;
            if (count !== 5'd18 || outdecod !== 5'd18) begin
                errors++; $display("FAIL load_busy_count got=%0d dec=%0d exp=18", count, outdecod);
            end
            drive(1'b0, 1'b0, 1'b0, '0);
            settle();
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL load18_busy_len got=%0d exp=4", n); end
        checks++;
        if (outdecod !== 5'h1f) begin errors++; $display("FAIL load18_outdecod got=%0d exp=31", outdecod); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0);
            settle();
            checks++;
            if (outled !== 1'b0) begin errors++; $display("FAIL load_no_led got=%0b exp=0", outled); end
        end
        checks++;
        if (boom_total !== tot0) begin errors++; $display("FAIL load_total got=%0d exp=%0d", boom_total, tot0); end
    endtask

    task automatic test_busy_ignore();
        drive(1'b0, 1'b0, 1'b1, 5'd20);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, '0);
        wait_idle();
        checks++;
        if (count !== 5'd20) begin errors++; $display("FAIL busy_step_ignored got=%0d exp=20", count); end
        drive(1'b0, 1'b1, 1'b1, 5'd9);
        wait_idle();
        checks++;
        if (count !== 5'd9) begin errors++; $display("FAIL load_beats_step got=%0d exp=9", count); end
    endtask

    task automatic test_mode1_back_to_back();
        logic [6:0] led_v;
        cur_mode = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 5'd15);
        wait_idle();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, i < 3, 1'b0, '0);
            settle();
            led_v[i] = outled;
            if (i == 0) begin
                checks++;
                if (outdecod !== 5'h1f) begin errors++; $display("FAIL mode1_16 got=%0d exp=31", outdecod); end
            end
            if (i == 1) begin
                checks++;
                if (outdecod !== 5'd17) begin errors++; $display("FAIL mode1_17 got=%0d exp=17", outdecod); end
            end
        end
        checks++;
        if (led_v !== 7'b0111110) begin
            errors++; $display("FAIL led_merge got=%b exp=0111110", led_v);
        end
    endtask

    task automatic test_reset_mid_calc();
        cur_mode = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 5'd30);
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
        settle();
        checks++;
        if (count !== 5'd0 || busy !== 1'b0 || outled !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_calc got count=%0d busy=%0b led=%0b exp 0/0/0", count, busy, outled);
        end
        drive(1'b0, 1'b1, 1'b0, '0);
        settle();
        checks++;
        if (count !== 5'd1 || outdecod !== 5'd1) begin
            errors++; $display("FAIL rst_then_step got count=%0d dec=%0d exp 1/1", count, outdecod);
        end
    endtask

    task automatic test_saturate();
        cur_mode = 1'b1;
        for (int i = 0; i < 1300; i++) drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, '0);
        settle();
        checks++;
        if (boom_total !== 8'hff) begin errors++; $display("FAIL total_saturate got=%0d exp=255", boom_total); end
    endtask

    initial begin
        rst = 1'b1; step = 1'b0; load = 1'b0; load_val = '0; mode = 1'b0; cur_mode = 1'b0;
        m_count = '0; m_busy = 0; m_pend = 1'b0; m_hold = 0; m_total = 0; m_wrap = 1'b0;
        test_reset();
        test_step_boom();
        test_wrap();
        test_load_boom();
        test_busy_ignore();
        test_mode1_back_to_back();
        test_reset_mid_calc();
        test_saturate();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) settle();
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
